// File: rtl/cdc_pkg.sv
// Shared types and defaults for the clock-domain-crossing handshake arbiter.
//   hs_state_t       : handshake FSM state encoding
//   SYNC_STAGES_DEF  : default ack synchronizer depth
//   TIMEOUT_CYC_DEF  : default per-phase timeout in source clock cycles
package cdc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } hs_state_t;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int TIMEOUT_CYC_DEF = 1024;

endpackage

// File: rtl/cdc_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first set request at or after ptr_i,
// wrapping around.
//   req_i : request vector
//   ptr_i : index where the search starts
//   gnt_o : one-hot grant (all zero when no request)
module cdc_rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] gnt_o
);

    int   idx;
    logic found;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            // ptr_i is always < NUM_REQ, so a single wrap is enough
            idx = int'(ptr_i) + off;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req_i[idx[ID_W-1:0]]) begin
                gnt_o[idx[ID_W-1:0]] = 1'b1;
                found                = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdc_hs_arb_ctrl.sv
// Arbitrates NUM_REQ source-domain requesters onto a single 4-phase req/ack
// handshake towards an asynchronous destination domain.
//   clock, arst_n      : source clock, async active-low reset
//   req_valid/req_data : per-requester request and payload (held until req_ready)
//   req_ready          : one-hot accept strobe (single cycle)
//   xfer_req/xfer_data : registered level request and payload to destination
//   xfer_ack_async     : destination acknowledge, synchronized internally
//   grant_id           : index of requester being serviced
//   busy, done         : FSM not IDLE / handshake-complete pulse
//   err_clr            : clears sticky timeout_err
//   timeout_err        : set when a phase exceeds TIMEOUT_CYC cycles
module cdc_hs_arb_ctrl
    import cdc_pkg::*;
#(
    parameter  int NUM_REQ     = 4,
    parameter  int DATA_W      = 32,
    parameter  int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter  int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    localparam int ID_W        = $clog2(NUM_REQ)
) (
    input  logic                            clock,
    input  logic                            arst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic                            xfer_req,
    output logic [DATA_W-1:0]               xfer_data,
    input  logic                            xfer_ack_async,
    output logic [ID_W-1:0]                 grant_id,
    output logic                            busy,
    output logic                            done,
    input  logic                            err_clr,
    output logic                            timeout_err
);

    localparam int              CNT_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;
    logic ack_s;

    hs_state_t          state_q, state_d;
    logic               xfer_req_q, xfer_req_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [ID_W-1:0]    gid_q, gid_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic               accept;
    logic               tmo_hit;

    // Only this chain ever samples the asynchronous ack.
    always_ff @(posedge clock or negedge arst_n) begin
        if (!arst_n) sync_q <= '0;
        else         sync_q <= {sync_q[SYNC_STAGES-2:0], xfer_ack_async};
    end
    assign ack_s = sync_q[SYNC_STAGES-1];

    cdc_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .gnt_o (gnt)
    );

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (gnt[i]) gnt_idx = ID_W'(i);
    end

    // done_q blocks a grant in the completion cycle so a new handshake never
    // starts before the requester has seen done. arst_n keeps req_ready low
    // while reset is asserted even though the FSM is combinationally IDLE.
    assign accept    = arst_n && (state_q == IDLE) && (|req_valid) && !ack_s && !done_q;
    assign req_ready = accept ? gnt : '0;

    always_comb begin
        state_d    = state_q;
        xfer_req_d = xfer_req_q;
        data_d     = data_q;
        gid_d      = gid_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d    = REQ;
                    xfer_req_d = 1'b1;
                    data_d     = req_data[gnt_idx];
                    gid_d      = gnt_idx;
                    ptr_d      = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                    cnt_d      = '0;
                end
            end
            REQ: begin
                if (ack_s) begin
                    state_d    = DROP;
                    xfer_req_d = 1'b0;
                    cnt_d      = '0;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DROP: begin
                if (!ack_s) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = IDLE;
                xfer_req_d = 1'b0;
            end
        endcase
    end

    // Counter saturates at CNT_MAX, so the hit condition fires once per phase.
    assign tmo_hit = (state_q != IDLE) && (state_d == state_q) && (cnt_q == CNT_MAX - 1'b1);
    assign err_d   = tmo_hit | (err_q & ~err_clr);

    always_ff @(posedge clock or negedge arst_n) begin
        if (!arst_n) begin
            state_q    <= IDLE;
            xfer_req_q <= 1'b0;
            data_q     <= '0;
            gid_q      <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            xfer_req_q <= xfer_req_d;
            data_q     <= data_d;
            gid_q      <= gid_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign xfer_req    = xfer_req_q;
    assign xfer_data   = data_q;
    assign grant_id    = gid_q;
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign timeout_err = err_q;

endmodule
